// File: rtl/stack_sequencer.sv
// stack_sequencer: pushes/pops PC and flag words on a downward-growing
// data-memory stack for CALL, RET, INT and RTI, one word per cycle.
// Define STACK_GUARD_EN to enable the stack-guard logic. Without it,
// stack_err is tied low and the stack pointer wraps modulo 2^ADDR_W.
module stack_sequencer #(
   parameter int                ADDR_W  = 20,
   parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [31:0]       pc_in,
   input  logic [2:0]        flags_in,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic [31:0]       pc_out,
   output logic              pc_load,
   output logic [2:0]        flags_out,
   output logic              flags_load,
   output logic [ADDR_W-1:0] sp,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic              stack_err
);

   typedef enum logic [2:0] {
      IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI, FIN
   } state_t;

   localparam logic [1:0] OP_CALL = 2'b00;
   localparam logic [1:0] OP_RET  = 2'b01;
   localparam logic [1:0] OP_INT  = 2'b10;
   localparam logic [1:0] OP_RTI  = 2'b11;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] sp_q, sp_d, sp_inc, sp_dec;
   logic [1:0]        op_q;
   logic [31:0]       pc_q;
   logic [2:0]        flags_q;
   logic [15:0]       lo_q;
   logic [2:0]        flg_pop_q;
   logic [31:0]       pc_hold_q;
   logic [2:0]        flags_hold_q;
   logic              start_acc;
   logic              push_block, pop_block;

   assign sp_inc    = sp_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign sp_dec    = sp_q - {{(ADDR_W-1){1'b0}}, 1'b1};
   // rst_n gates acceptance so stall reads 0 while reset is held
   assign start_acc = (state_q == IDLE) && start && rst_n;
   assign busy      = (state_q != IDLE);
   assign stall     = start_acc | busy;
   assign sp        = sp_q;

`ifdef STACK_GUARD_EN
   assign push_block = (sp_q == '0);
   assign pop_block  = (sp_q == SP_INIT);
   assign stack_err  = (((state_q == PUSH_HI) || (state_q == PUSH_LO) ||
                         (state_q == PUSH_FLG)) && push_block) ||
                       (((state_q == POP_FLG) || (state_q == POP_LO) ||
                         (state_q == POP_HI)) && pop_block);
`else
   assign push_block = 1'b0;
   assign pop_block  = 1'b0;
   assign stack_err  = 1'b0;
`endif

   // FIN forwards the word arriving this cycle; otherwise hold last load
   assign pc_out    = (state_q == FIN) ? {mem_rdata, lo_q} : pc_hold_q;
   assign flags_out = flags_load ? flg_pop_q : flags_hold_q;

   // Control registers: state, stack pointer and latched opcode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sp_q    <= SP_INIT;
         op_q    <= OP_CALL;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         if (start_acc) op_q <= op;
      end
   end

   // Data capture: request operands and popped words (no reset needed)
   always_ff @(posedge clk) begin
      if (start_acc) begin
         pc_q    <= pc_in;
         flags_q <= flags_in;
      end
      if (state_q == POP_LO) flg_pop_q <= mem_rdata[2:0];
      if (state_q == POP_HI) lo_q      <= mem_rdata;
   end

   // Output hold registers keep pc_out/flags_out stable between loads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_hold_q    <= '0;
         flags_hold_q <= '0;
      end else begin
         if (pc_load)    pc_hold_q    <= pc_out;
         if (flags_load) flags_hold_q <= flags_out;
      end
   end

   // Next-state, memory strobes and completion pulses
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      done       = 1'b0;
      pc_load    = 1'b0;
      flags_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_acc) begin
               case (op)
                  OP_CALL, OP_INT: state_d = PUSH_HI;
                  OP_RET:          state_d = POP_LO;
                  default:         state_d = POP_FLG;
               endcase
            end
         end
         PUSH_HI, PUSH_LO, PUSH_FLG: begin
            if (push_block) begin
               state_d = IDLE;
            end else begin
               mem_we   = 1'b1;
               mem_addr = sp_q;
               sp_d     = sp_dec;
               case (state_q)
                  PUSH_HI: begin
                     mem_wdata = pc_q[31:16];
                     state_d   = PUSH_LO;
                  end
                  PUSH_LO: begin
                     mem_wdata = pc_q[15:0];
                     if (op_q == OP_INT) begin
                        state_d = PUSH_FLG;
                     end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                     end
                  end
                  default: begin
                     mem_wdata = {13'b0, flags_q};
                     state_d   = IDLE;
                     done      = 1'b1;
                  end
               endcase
            end
         end
         POP_FLG, POP_LO, POP_HI: begin
            if (pop_block) begin
               state_d = IDLE;
            end else begin
               mem_re   = 1'b1;
               mem_addr = sp_inc;
               sp_d     = sp_inc;
               case (state_q)
                  POP_FLG: state_d = POP_LO;
                  POP_LO:  state_d = POP_HI;
                  default: state_d = FIN;
               endcase
            end
         end
         FIN: begin
            pc_load    = 1'b1;
            flags_load = (op_q == OP_RTI);
            done       = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios followed by
// randomized balanced push/pop traffic against a word-level stack model.
module tb_stack_sequencer;

   localparam int          AW      = 20;
   localparam logic [19:0] SP_INIT = 20'hFFFFF;
   localparam logic [1:0]  CALL = 2'b00, RET = 2'b01, INT = 2'b10, RTI = 2'b11;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk, rst_n, start;
   logic [1:0]    op;
   logic [31:0]   pc_in;
   logic [2:0]    flags_in;
   logic [15:0]   mem_rdata;
   logic [AW-1:0] mem_addr, sp;
   logic [15:0]   mem_wdata;
   logic          mem_we, mem_re, pc_load, flags_load, busy, stall, done, stack_err;
   logic [31:0]   pc_out;
   logic [2:0]    flags_out;

   stack_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .pc_in(pc_in),
      .flags_in(flags_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .pc_out(pc_out), .pc_load(pc_load), .flags_out(flags_out),
      .flags_load(flags_load), .sp(sp), .busy(busy), .stall(stall),
      .done(done), .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Device-side memory seen by the DUT
   logic [15:0] dev_mem [logic [19:0]];
   always @(posedge clk) begin
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
      if (mem_re) mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : 16'h0;
   end

   // Reference model state
   typedef struct packed {
      logic        we;
      logic        re;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic        done;
      logic        pl;
      logic        fl;
      logic        err;
      logic [31:0] pco;
      logic [2:0]  flo;
   } cyc_t;

   logic [15:0] model_mem [logic [19:0]];
   logic [19:0] m_sp;
   logic [31:0] m_pc_out;
   logic [2:0]  m_flags_out;
   cyc_t        exp_q [$];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] model_rd(input logic [19:0] a);
      return model_mem.exists(a) ? model_mem[a] : 16'h0;
   endfunction

   task automatic model_reset();
      m_sp        = SP_INIT;
      m_pc_out    = '0;
      m_flags_out = '0;
   endtask

   // Expected cycle-by-cycle behaviour of one sequence, derived from the
   // list of words moved to or from the stack
   task automatic build(input logic [1:0] o, input logic [31:0] pc, input logic [2:0] fl);
      logic [15:0] w [$];
      logic [15:0] r [$];
      cyc_t        c;
      int          npop;
      exp_q.delete();
      if (o == CALL || o == INT) begin
         w.push_back(pc[31:16]);
         w.push_back(pc[15:0]);
         if (o == INT) w.push_back({13'b0, fl});
         foreach (w[k]) begin
            c = '0;
            if (GUARD && m_sp == 20'h0) begin
               c.err = 1'b1;
               exp_q.push_back(c);
               return;
            end
            c.we = 1'b1; c.addr = m_sp; c.wdata = w[k];
            c.done = (k == w.size() - 1);
            model_mem[m_sp] = w[k];
            m_sp = m_sp - 20'h1;
            exp_q.push_back(c);
         end
      end else begin
         npop = (o == RTI) ? 3 : 2;
         for (int k = 0; k < npop; k++) begin
            c = '0;
            if (GUARD && m_sp == SP_INIT) begin
               c.err = 1'b1;
               exp_q.push_back(c);
               return;
            end
            m_sp = m_sp + 20'h1;
            c.re = 1'b1; c.addr = m_sp;
            r.push_back(model_rd(m_sp));
            exp_q.push_back(c);
         end
         c = '0;
         c.pl = 1'b1; c.done = 1'b1;
         if (o == RTI) begin
            c.fl = 1'b1; c.flo = r[0][2:0]; c.pco = {r[2], r[1]};
            m_flags_out = r[0][2:0];
         end else begin
            c.pco = {r[1], r[0]};
         end
         m_pc_out = c.pco;
         exp_q.push_back(c);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
      chk({tag, "_we"}, 64'(mem_we), 64'(0));
      chk({tag, "_re"}, 64'(mem_re), 64'(0));
      chk({tag, "_pc_out"}, 64'(pc_out), 64'(0));
      chk({tag, "_pc_load"}, 64'(pc_load), 64'(0));
      chk({tag, "_flags_out"}, 64'(flags_out), 64'(0));
      chk({tag, "_flags_load"}, 64'(flags_load), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_stall"}, 64'(stall), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_err"}, 64'(stack_err), 64'(0));
      chk({tag, "_sp"}, 64'(sp), 64'(SP_INIT));
   endtask

   // Run one sequence; inject drives start during busy/done cycles,
   // rst_at (1-based busy cycle, 0 = none) asserts reset mid-sequence
   task automatic do_op(input logic [1:0] o, input logic [31:0] pc, input logic [2:0] fl,
                        input bit inject, input int rst_at);
      logic [31:0] old_pc;
      logic [2:0]  old_fl;
      cyc_t        e;
      old_pc = m_pc_out;
      old_fl = m_flags_out;
      build(o, pc, fl);
      start = 1'b1; op = o; pc_in = pc; flags_in = fl;
      #1;
      chk("start_stall", 64'(stall), 64'(1));
      chk("start_busy", 64'(busy), 64'(0));
      foreach (exp_q[i]) begin
         @(negedge clk);
         start = inject;
         if (inject) begin
            op = 2'($urandom); pc_in = $urandom; flags_in = 3'($urandom);
         end
         if (i + 1 == rst_at) begin
            start = 1'b0;
            rst_n = 1'b0;
            #1;
            chk_reset("mid_reset");
            model_reset();
            @(negedge clk);
            chk_reset("held_reset");
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               #1;
               chk("post_rst_pc_load", 64'(pc_load), 64'(0));
               chk("post_rst_busy", 64'(busy), 64'(0));
               chk("post_rst_re", 64'(mem_re), 64'(0));
            end
            return;
         end
         #1;
         e = exp_q[i];
         chk("we", 64'(mem_we), 64'(e.we));
         chk("re", 64'(mem_re), 64'(e.re));
         if (e.we || e.re) chk("addr", 64'(mem_addr), 64'(e.addr));
         if (e.we) chk("wdata", 64'(mem_wdata), 64'(e.wdata));
         chk("done", 64'(done), 64'(e.done));
         chk("pc_load", 64'(pc_load), 64'(e.pl));
         chk("flags_load", 64'(flags_load), 64'(e.fl));
         chk("err", 64'(stack_err), 64'(e.err));
         chk("busy", 64'(busy), 64'(1));
         chk("stall", 64'(stall), 64'(1));
         if (e.pl) chk("pc_out", 64'(pc_out), 64'(e.pco));
         else      chk("pc_hold", 64'(pc_out), 64'(old_pc));
         if (e.fl) chk("flags_out", 64'(flags_out), 64'(e.flo));
         else      chk("flags_hold", 64'(flags_out), 64'(old_fl));
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_stall", 64'(stall), 64'(0));
      chk("idle_we", 64'(mem_we), 64'(0));
      chk("idle_re", 64'(mem_re), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_pc_load", 64'(pc_load), 64'(0));
      chk("idle_sp", 64'(sp), 64'(m_sp));
      chk("idle_pc_out", 64'(pc_out), 64'(m_pc_out));
      chk("idle_flags_out", 64'(flags_out), 64'(m_flags_out));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rpc;
      logic [2:0]  rfl;
      logic [31:0] frames [$];
      rst_n = 1'b0; start = 1'b0; op = 2'b00; pc_in = '0; flags_in = '0;
      mem_rdata = '0;
      model_reset();

      // Reset state
      @(negedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // CALL 0001_2345 from the top of the stack
      do_op(CALL, 32'h0001_2345, 3'b000, 1'b0, 0);
      chk("req022_hi", 64'(dev_mem[20'hFFFFF]), 64'(16'h0001));
      chk("req022_lo", 64'(dev_mem[20'hFFFFE]), 64'(16'h2345));
      chk("req022_sp", 64'(sp), 64'(20'hFFFFD));

      // Matching RET
      do_op(RET, 32'h0, 3'b000, 1'b0, 0);
      chk("req023_pc", 64'(pc_out), 64'(32'h0001_2345));
      chk("req023_sp", 64'(sp), 64'(20'hFFFFF));

      // INT then RTI, with start hammered during busy and done cycles
      do_op(INT, 32'hABCD_0010, 3'b101, 1'b1, 0);
      chk("req024_w0", 64'(dev_mem[20'hFFFFF]), 64'(16'hABCD));
      chk("req024_w1", 64'(dev_mem[20'hFFFFE]), 64'(16'h0010));
      chk("req024_w2", 64'(dev_mem[20'hFFFFD]), 64'(16'h0005));
      do_op(RTI, 32'h0, 3'b000, 1'b1, 0);
      chk("req024_pc", 64'(pc_out), 64'(32'hABCD_0010));
      chk("req024_flags", 64'(flags_out), 64'(3'b101));
      chk("req024_sp", 64'(sp), 64'(20'hFFFFF));

      // RET on an empty stack
      do_op(RET, 32'h0, 3'b000, 1'b0, 0);
`ifdef STACK_GUARD_EN
      chk("req027_sp", 64'(sp), 64'(20'hFFFFF));
`else
      chk("req027_sp", 64'(sp), 64'(20'h00001));
`endif
      // Reset to restore the stack pointer
      rst_n = 1'b0;
      #1;
      chk_reset("restore_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset during RET POP_HI
      do_op(CALL, 32'h1234_5678, 3'b000, 1'b0, 0);
      do_op(RET, 32'h0, 3'b000, 1'b0, 2);

      // Randomized balanced traffic
      for (int n = 0; n < 300; n++) begin
         if (frames.size() == 0 || (frames.size() < 40 && $urandom_range(0, 1) == 1)) begin
            rpc = $urandom;
            rfl = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               do_op(INT, rpc, rfl, 1'($urandom), 0);
               frames.push_back(32'd1);
            end else begin
               do_op(CALL, rpc, rfl, 1'($urandom), 0);
               frames.push_back(32'd0);
            end
         end else begin
            if (frames.pop_back() == 32'd1) do_op(RTI, 32'h0, 3'b000, 1'($urandom), 0);
            else                            do_op(RET, 32'h0, 3'b000, 1'($urandom), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
